// File: rtl/hazard_input_conditioner.sv
// Switch front end for the hazard-light FSM: synchronizes and debounces the
// wind-direction switches, rejects the illegal 11 code, and paces the FSM with step_tick.
module hazard_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int TICK_DIV        = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sw_raw,
    output logic [1:0] mode_out,
    output logic       mode_changed,
    output logic       illegal_sw,
    output logic       step_tick
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DCNT_ONE   = DW'(1);
    localparam logic [TW-1:0] TCNT_LAST  = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TCNT_ONE   = TW'(1);
    localparam logic [1:0]    SW_ILLEGAL = 2'b11;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      s1_q, s2_q;
    logic [1:0]      cand_q, cand_d;
    logic [1:0]      mode_q, mode_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            changed_q, changed_d;
    logic            illegal_q, illegal_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= 2'b00;
            s2_q      <= 2'b00;
            cand_q    <= 2'b00;
            mode_q    <= 2'b00;
            dcnt_q    <= '0;
            tcnt_q    <= '0;
            state_q   <= STABLE;
            changed_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            s1_q      <= sw_raw;
            s2_q      <= s1_q;
            cand_q    <= cand_d;
            mode_q    <= mode_d;
            dcnt_q    <= dcnt_d;
            tcnt_q    <= tcnt_d;
            state_q   <= state_d;
            changed_q <= changed_d;
            illegal_q <= illegal_d;
        end
    end

    // Debounce: any disagreement with the candidate restarts the settle count.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        dcnt_d    = dcnt_q;
        mode_d    = mode_q;
        illegal_d = illegal_q;
        changed_d = 1'b0;
        if (s2_q != cand_q) begin
            cand_d  = s2_q;
            dcnt_d  = '0;
            state_d = SETTLING;
        end else if (state_q == SETTLING) begin
            if (dcnt_q == DCNT_LAST) begin
                state_d = STABLE;
                if (cand_q == SW_ILLEGAL) begin
                    illegal_d = 1'b1;
                end else begin
                    illegal_d = 1'b0;
                    if (cand_q != mode_q) begin
                        mode_d    = cand_q;
                        changed_d = 1'b1;
                    end
                end
            end else begin
                dcnt_d = dcnt_q + DCNT_ONE;
            end
        end
    end

    // A fresh mode restarts the tick period so it gets a full step before advancing.
    always_comb begin
        tcnt_d = tcnt_q + TCNT_ONE;
        if (changed_d || (tcnt_q == TCNT_LAST)) begin
            tcnt_d = '0;
        end
    end

    assign mode_out     = mode_q;
    assign mode_changed = changed_q;
    assign illegal_sw   = illegal_q;
    assign step_tick    = (tcnt_q == TCNT_LAST);

endmodule

// File: tb/tb_hazard_input_conditioner.sv
// Bench for hazard_input_conditioner: directed scenarios plus random switch activity,
// checked against a run-length / modulo-count reference model.
module tb_hazard_input_conditioner;

    localparam int DC  = 4;
    localparam int TD  = 5;
    localparam int SAT = DC + 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sw_raw = 2'b00;
    logic [1:0] mode_out;
    logic       mode_changed;
    logic       illegal_sw;
    logic       step_tick;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [1:0] m_h1 = 2'b00, m_h2 = 2'b00;
    logic [1:0] m_prev = 2'b00;
    int         m_run = SAT;
    logic [1:0] m_mode = 2'b00;
    logic       m_chg = 1'b0;
    logic       m_ill = 1'b0;
    int         m_since = 0;
    logic       e_tick = 1'b0;

    hazard_input_conditioner #(
        .DEBOUNCE_CYCLES(DC),
        .TICK_DIV(TD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw_raw(sw_raw),
        .mode_out(mode_out),
        .mode_changed(mode_changed),
        .illegal_sw(illegal_sw),
        .step_tick(step_tick)
    );

    always #5 clk = ~clk;

    // Apply one clock with the given inputs, advance the model, settle 1 time unit.
    task automatic cycle(input logic [1:0] sw, input logic rst);
        logic [1:0] s2v;
        logic       restart;
        sw_raw = sw;
        reset  = rst;
        @(posedge clk);
        restart = 1'b0;
        m_chg   = 1'b0;
        if (rst) begin
            m_h1 = 2'b00; m_h2 = 2'b00; m_prev = 2'b00; m_run = SAT;
            m_mode = 2'b00; m_ill = 1'b0; m_since = 0;
        end else begin
            s2v  = m_h2;
            m_h2 = m_h1;
            m_h1 = sw;
            if (s2v != m_prev) begin
                m_prev = s2v;
                m_run  = 1;
            end else if (m_run < SAT) begin
                m_run++;
            end
            if (m_run == DC + 1) begin
                if (m_prev == 2'b11) begin
                    m_ill = 1'b1;
                end else begin
                    m_ill = 1'b0;
                    if (m_prev != m_mode) begin
                        m_mode  = m_prev;
                        m_chg   = 1'b1;
                        restart = 1'b1;
                    end
                end
            end
            m_since = restart ? 0 : m_since + 1;
        end
        e_tick = ((m_since % TD) == TD - 1);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) cycle(2'b00, 1'b1);
        n_vec++;
        if ({mode_out, mode_changed, illegal_sw, step_tick} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_state: got %b, expected 00000", {mode_out, mode_changed, illegal_sw, step_tick});
        end
        for (int i = 1; i <= 10; i++) begin
            cycle(2'b00, 1'b0);
            n_vec++;
            if ({mode_out, mode_changed, illegal_sw, step_tick} !== {m_mode, m_chg, m_ill, e_tick}) begin
                n_err++;
                $display("FAIL reset_model i=%0d: got %b, expected %b", i,
                         {mode_out, mode_changed, illegal_sw, step_tick}, {m_mode, m_chg, m_ill, e_tick});
            end
            n_vec++;
            if (step_tick !== (i % TD == TD - 1)) begin
                n_err++;
                $display("FAIL reset_tick_phase i=%0d: got %b", i, step_tick);
            end
        end
    endtask

    task automatic test_single_commit();
        for (int n = 1; n <= 12; n++) begin
            cycle(2'b01, 1'b0);
            n_vec++;
            if ({mode_out, mode_changed, illegal_sw, step_tick} !== {m_mode, m_chg, m_ill, e_tick}) begin
                n_err++;
                $display("FAIL single_model n=%0d: got %b, expected %b", n,
                         {mode_out, mode_changed, illegal_sw, step_tick}, {m_mode, m_chg, m_ill, e_tick});
            end
            n_vec++;
            if (mode_out !== (n >= 7 ? 2'b01 : 2'b00) || mode_changed !== (n == 7)) begin
                n_err++;
                $display("FAIL single_latency n=%0d: got mode=%b chg=%b", n, mode_out, mode_changed);
            end
            if (n >= 7) begin
                n_vec++;
                if (step_tick !== (n == 11)) begin
                    n_err++;
                    $display("FAIL single_tick_restart n=%0d: got %b", n, step_tick);
                end
            end
        end
    endtask

    task automatic test_bounce();
        int a, b;
        a = $urandom_range(1, 3);
        b = $urandom_range(1, 3);
        for (int i = 0; i < a; i++) cycle(2'b10, 1'b0);
        for (int i = 0; i < b; i++) cycle(2'b00, 1'b0);
        for (int m = 1; m <= 12; m++) begin
            cycle(2'b10, 1'b0);
            n_vec++;
            if ({mode_out, mode_changed, illegal_sw, step_tick} !== {m_mode, m_chg, m_ill, e_tick}) begin
                n_err++;
                $display("FAIL bounce_model m=%0d: got %b, expected %b", m,
                         {mode_out, mode_changed, illegal_sw, step_tick}, {m_mode, m_chg, m_ill, e_tick});
            end
            n_vec++;
            if (mode_out !== (m >= 7 ? 2'b10 : 2'b01) || mode_changed !== (m == 7)) begin
                n_err++;
                $display("FAIL bounce_restart m=%0d a=%0d b=%0d: got mode=%b chg=%b", m, a, b, mode_out, mode_changed);
            end
        end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 8; i++) cycle(2'b01, 1'b0);
        for (int m = 1; m <= 10; m++) begin
            cycle(2'b11, 1'b0);
            n_vec++;
            if ({mode_out, mode_changed, illegal_sw, step_tick} !== {m_mode, m_chg, m_ill, e_tick}) begin
                n_err++;
                $display("FAIL illegal_model m=%0d: got %b, expected %b", m,
                         {mode_out, mode_changed, illegal_sw, step_tick}, {m_mode, m_chg, m_ill, e_tick});
            end
            n_vec++;
            if (mode_out !== 2'b01 || mode_changed !== 1'b0 || illegal_sw !== (m >= 7)) begin
                n_err++;
                $display("FAIL illegal_hold m=%0d: got mode=%b chg=%b ill=%b", m, mode_out, mode_changed, illegal_sw);
            end
        end
        for (int m = 1; m <= 10; m++) begin
            cycle(2'b01, 1'b0);
            n_vec++;
            if ({mode_out, mode_changed, illegal_sw, step_tick} !== {m_mode, m_chg, m_ill, e_tick}) begin
                n_err++;
                $display("FAIL illegal_clear_model m=%0d: got %b, expected %b", m,
                         {mode_out, mode_changed, illegal_sw, step_tick}, {m_mode, m_chg, m_ill, e_tick});
            end
            n_vec++;
            if (mode_out !== 2'b01 || mode_changed !== 1'b0 || illegal_sw !== (m < 7)) begin
                n_err++;
                $display("FAIL illegal_clear m=%0d: got mode=%b chg=%b ill=%b", m, mode_out, mode_changed, illegal_sw);
            end
        end
    endtask

    task automatic test_reset_mid_settle();
        for (int i = 0; i < 4; i++) cycle(2'b10, 1'b0);
        cycle(2'b10, 1'b1);
        n_vec++;
        if ({mode_out, mode_changed, illegal_sw, step_tick} !== 5'b00000) begin
            n_err++;
            $display("FAIL midreset_state: got %b, expected 00000", {mode_out, mode_changed, illegal_sw, step_tick});
        end
        for (int m = 1; m <= 10; m++) begin
            cycle(2'b10, 1'b0);
            n_vec++;
            if ({mode_out, mode_changed, illegal_sw, step_tick} !== {m_mode, m_chg, m_ill, e_tick}) begin
                n_err++;
                $display("FAIL midreset_model m=%0d: got %b, expected %b", m,
                         {mode_out, mode_changed, illegal_sw, step_tick}, {m_mode, m_chg, m_ill, e_tick});
            end
            n_vec++;
            if (mode_out !== (m >= 7 ? 2'b10 : 2'b00) || mode_changed !== (m == 7) || illegal_sw !== 1'b0) begin
                n_err++;
                $display("FAIL midreset_recommit m=%0d: got mode=%b chg=%b ill=%b", m, mode_out, mode_changed, illegal_sw);
            end
            if (m < 7) begin
                n_vec++;
                if (step_tick !== (m == 4)) begin
                    n_err++;
                    $display("FAIL midreset_tick m=%0d: got %b", m, step_tick);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        logic [1:0] seq [2];
        seq[0] = 2'b10;
        seq[1] = 2'b01;
        pulses = 0;
        for (int i = 0; i < 8; i++) cycle(2'b01, 1'b0);
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
                cycle(seq[s], 1'b0);
                if (mode_changed === 1'b1) pulses++;
                n_vec++;
                if ({mode_out, mode_changed, illegal_sw, step_tick} !== {m_mode, m_chg, m_ill, e_tick}) begin
                    n_err++;
                    $display("FAIL b2b_model s=%0d i=%0d: got %b, expected %b", s, i,
                             {mode_out, mode_changed, illegal_sw, step_tick}, {m_mode, m_chg, m_ill, e_tick});
                end
                n_vec++;
                if (mode_changed === 1'b1 && step_tick === 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_coincident s=%0d i=%0d: mode_changed=1 step_tick=1, required not both", s, i);
                end
            end
        end
        n_vec++;
        if (pulses != 2) begin
            n_err++;
            $display("FAIL b2b_pulse_count: got %0d, expected 2", pulses);
        end
    endtask

    task automatic test_random();
        logic [1:0] sw;
        int         len;
        logic       rst;
        for (int seg = 0; seg < 60; seg++) begin
            sw  = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 9);
            rst = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < len; i++) begin
                cycle(sw, (i == 0) ? rst : 1'b0);
                n_vec++;
                if ({mode_out, mode_changed, illegal_sw, step_tick} !== {m_mode, m_chg, m_ill, e_tick}) begin
                    n_err++;
                    $display("FAIL random_model seg=%0d i=%0d sw=%b: got %b, expected %b", seg, i, sw,
                             {mode_out, mode_changed, illegal_sw, step_tick}, {m_mode, m_chg, m_ill, e_tick});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_commit();
        test_bounce();
        test_illegal();
        test_reset_mid_settle();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
